// File: rtl/rx_unstuff_deserializer.sv
// rx_unstuff_deserializer: full-speed receive stage.
// Hunts for SYNC in the NRZI-decoded bit stream, removes stuffed zeros,
// assembles bytes LSB-first and flags end-of-packet / stuffing violations.
// Optional feature macro: USB_RX_STUFF_ERR_CHECK_EN
//   defined   - a 1 after six consecutive ones aborts the packet (stuff_err_o)
//   undefined - that bit is dropped like a stuffed zero, stuff_err_o stays 0
module rx_unstuff_deserializer #(
  parameter int unsigned SYNC_MIN_ZEROS = 3
) (
  input  logic       clk12_i,
  input  logic       rst_ni,
  input  logic       data_i,
  input  logic       valid_i,
  input  logic       se0_i,
  output logic       sync_o,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       eop_o,
  output logic       eop_aligned_o,
  output logic       stuff_err_o
);

  localparam logic [2:0] SYNC_MIN = 3'(SYNC_MIN_ZEROS);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t     state_reg, state_next;
  logic [2:0] zero_cnt_reg, zero_cnt_next;
  logic [2:0] ones_cnt_reg, ones_cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] sr_reg, sr_next;
  logic [7:0] byte_reg, byte_next;
  logic       sync_reg, sync_next;
  logic       byte_valid_reg, byte_valid_next;
  logic       eop_reg, eop_next;
  logic       eop_aligned_reg, eop_aligned_next;
  logic       stuff_err_reg, stuff_err_next;

  // Register all state and outputs; reset drops straight to IDLE with quiet outputs.
  always_ff @(posedge clk12_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      zero_cnt_reg    <= 3'd0;
      ones_cnt_reg    <= 3'd0;
      bit_cnt_reg     <= 3'd0;
      sr_reg          <= 8'h00;
      byte_reg        <= 8'h00;
      sync_reg        <= 1'b0;
      byte_valid_reg  <= 1'b0;
      eop_reg         <= 1'b0;
      eop_aligned_reg <= 1'b0;
      stuff_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      zero_cnt_reg    <= zero_cnt_next;
      ones_cnt_reg    <= ones_cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      sr_reg          <= sr_next;
      byte_reg        <= byte_next;
      sync_reg        <= sync_next;
      byte_valid_reg  <= byte_valid_next;
      eop_reg         <= eop_next;
      eop_aligned_reg <= eop_aligned_next;
      stuff_err_reg   <= stuff_err_next;
    end
  end

  // Next-state and pulse decode; nothing moves unless a bit strobe is present.
  always_comb begin
    state_next       = state_reg;
    zero_cnt_next    = zero_cnt_reg;
    ones_cnt_next    = ones_cnt_reg;
    bit_cnt_next     = bit_cnt_reg;
    sr_next          = sr_reg;
    byte_next        = byte_reg;
    sync_next        = 1'b0;
    byte_valid_next  = 1'b0;
    eop_next         = 1'b0;
    eop_aligned_next = 1'b0;
    stuff_err_next   = 1'b0;

    if (valid_i) begin
      case (state_reg)
        IDLE: begin
          if (se0_i) begin
            zero_cnt_next = 3'd0;
          end else if (!data_i) begin
            // Saturate so long idle-zero runs still qualify as a preamble.
            if (zero_cnt_reg != 3'd7) zero_cnt_next = zero_cnt_reg + 3'd1;
          end else if (zero_cnt_reg >= SYNC_MIN) begin
            // The terminating one of SYNC counts toward the first stuffing run.
            sync_next     = 1'b1;
            state_next    = RECV;
            ones_cnt_next = 3'd1;
            bit_cnt_next  = 3'd0;
            zero_cnt_next = 3'd0;
          end else begin
            zero_cnt_next = 3'd0;
          end
        end

        RECV: begin
          if (se0_i) begin
            // Any partial byte is simply abandoned; the next SYNC restarts bit_cnt.
            eop_next         = 1'b1;
            eop_aligned_next = (bit_cnt_reg == 3'd0);
            state_next       = IDLE;
            zero_cnt_next    = 3'd0;
          end else if (ones_cnt_reg == 3'd6) begin
`ifdef USB_RX_STUFF_ERR_CHECK_EN
            if (data_i) begin
              stuff_err_next = 1'b1;
              state_next     = DRAIN;
              bit_cnt_next   = 3'd0;
            end
`endif
            // Stuffed zero (or tolerated seventh one) carries no data.
            ones_cnt_next = 3'd0;
          end else begin
            sr_next       = {data_i, sr_reg[7:1]};
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            ones_cnt_next = data_i ? (ones_cnt_reg + 3'd1) : 3'd0;
            if (bit_cnt_reg == 3'd7) begin
              byte_next       = {data_i, sr_reg[7:1]};
              byte_valid_next = 1'b1;
            end
          end
        end

        DRAIN: begin
          // Aborted packet: wait silently for the line to go SE0.
          if (se0_i) begin
            state_next    = IDLE;
            zero_cnt_next = 3'd0;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  assign sync_o        = sync_reg;
  assign byte_o        = byte_reg;
  assign byte_valid_o  = byte_valid_reg;
  assign eop_o         = eop_reg;
  assign eop_aligned_o = eop_aligned_reg;
  assign stuff_err_o   = stuff_err_reg;

endmodule

// File: tb/tb_rx_unstuff_deserializer.sv
// Testbench for rx_unstuff_deserializer.
// Packets are described as SYNC + data bits; a bit-stuffing encoder builds the
// line symbols and tags the symbol that should cause each output pulse. The
// driver pushes those expectations as it issues the symbol; a monitor pops and
// compares them whenever the DUT pulses.
module tb_rx_unstuff_deserializer;

  localparam int EV_NONE = 0;
  localparam int EV_SYNC = 1;
  localparam int EV_BYTE = 2;
  localparam int EV_EOP  = 3;
  localparam int EV_ERR  = 4;

  typedef struct {
    logic       d;
    logic       se0;
    int         ev;
    logic [7:0] b;
    logic       al;
  } sym_t;

  typedef struct {
    int         ev;
    logic [7:0] b;
    logic       al;
    longint     cyc;
  } exp_t;

  logic       clk12_i = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       data_i  = 1'b0;
  logic       valid_i = 1'b0;
  logic       se0_i   = 1'b0;
  logic       sync_o;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       eop_o;
  logic       eop_aligned_o;
  logic       stuff_err_o;

  int     tests_run    = 0;
  int     tests_failed = 0;
  longint cyc          = 0;

  sym_t syms[$];
  exp_t exp_q[$];
  bit   dq[$];

  // Reference model state: data bits of the current partial byte and ones run.
  logic [7:0] m_acc;
  int         m_pending;
  int         m_ones;

  rx_unstuff_deserializer #(.SYNC_MIN_ZEROS(3)) dut (
    .clk12_i       (clk12_i),
    .rst_ni        (rst_ni),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .se0_i         (se0_i),
    .sync_o        (sync_o),
    .byte_o        (byte_o),
    .byte_valid_o  (byte_valid_o),
    .eop_o         (eop_o),
    .eop_aligned_o (eop_aligned_o),
    .stuff_err_o   (stuff_err_o)
  );

  always #5 clk12_i = ~clk12_i;

  // Cycle counter used to check pulse latency.
  always @(posedge clk12_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic check_ev(input int ev, input logic [7:0] b, input logic al);
    exp_t e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL event: unexpected kind=%0d byte=%h al=%0d at cyc %0d", ev, b, al, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.ev != ev || e.cyc != cyc || (ev == EV_BYTE && e.b !== b) ||
          (ev == EV_EOP && e.al !== al)) begin
        tests_failed++;
        $display("FAIL event: got kind=%0d byte=%h al=%0d cyc=%0d, expected kind=%0d byte=%h al=%0d cyc=%0d",
                 ev, b, al, cyc, e.ev, e.b, e.al, e.cyc);
      end else begin
        $display("[TB] ok event kind=%0d byte=%h al=%0d cyc=%0d", ev, b, al, cyc);
      end
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk12_i) begin
    if (rst_ni) begin
      if (sync_o)       check_ev(EV_SYNC, 8'h00, 1'b0);
      if (byte_valid_o) check_ev(EV_BYTE, byte_o, 1'b0);
      if (eop_o)        check_ev(EV_EOP, 8'h00, eop_aligned_o);
      if (stuff_err_o)  check_ev(EV_ERR, 8'h00, 1'b0);
    end
  end

  task automatic add_sym(input logic d, input logic s, input int ev,
                         input logic [7:0] b, input logic al);
    sym_t t;
    t.d = d; t.se0 = s; t.ev = ev; t.b = b; t.al = al;
    syms.push_back(t);
  endtask

  // n decoded zeros followed by the SYNC-terminating one.
  task automatic add_sync(input int nz);
    repeat (nz) add_sym(1'b0, 1'b0, EV_NONE, 8'h00, 1'b0);
    add_sym(1'b1, 1'b0, EV_SYNC, 8'h00, 1'b0);
    m_acc = 8'h00; m_pending = 0; m_ones = 1;
  endtask

  // One unstuffed data bit on the line; the 8th of a group yields a byte.
  task automatic add_data_bit(input logic d);
    m_acc[m_pending[2:0]] = d;
    m_pending++;
    if (m_pending == 8) begin
      add_sym(d, 1'b0, EV_BYTE, m_acc, 1'b0);
      m_pending = 0;
    end else begin
      add_sym(d, 1'b0, EV_NONE, 8'h00, 1'b0);
    end
  endtask

  // Bit-stuffing encoder: a zero goes on the line after every six ones.
  task automatic encode_dq();
    foreach (dq[i]) begin
      add_data_bit(dq[i]);
      m_ones = dq[i] ? m_ones + 1 : 0;
      if (m_ones == 6) begin
        add_sym(1'b0, 1'b0, EV_NONE, 8'h00, 1'b0);
        m_ones = 0;
      end
    end
    dq.delete();
  endtask

  task automatic add_eop();
    add_sym(1'b0, 1'b1, EV_EOP, 8'h00, m_pending == 0);
  endtask

  task automatic push_byte_bits(input logic [7:0] v);
    for (int k = 0; k < 8; k++) dq.push_back(v[k]);
  endtask

  task automatic push_rand_bits(input int n);
    for (int k = 0; k < n; k++) dq.push_back($urandom_range(0, 3) != 0);
  endtask

  // Drive the symbol list, optionally with idle gaps carrying junk inputs.
  task automatic run_syms(input bit gaps, input int stop_at);
    exp_t e;
    for (int i = 0; i < syms.size(); i++) begin
      if (stop_at >= 0 && i > stop_at) break;
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk12_i);
          valid_i = 1'b0; data_i = 1'($urandom); se0_i = 1'($urandom);
        end
      end
      @(negedge clk12_i);
      valid_i = 1'b1; data_i = syms[i].d; se0_i = syms[i].se0;
      if (syms[i].ev != EV_NONE) begin
        e.ev = syms[i].ev; e.b = syms[i].b; e.al = syms[i].al; e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
    end
    @(negedge clk12_i);
    valid_i = 1'b0; data_i = 1'b0; se0_i = 1'b0;
    syms.delete();
    repeat (3) @(negedge clk12_i);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_sync"},    {7'd0, sync_o},        8'h00);
    chk({tag, "_byte"},    byte_o,                8'h00);
    chk({tag, "_bvalid"},  {7'd0, byte_valid_o},  8'h00);
    chk({tag, "_eop"},     {7'd0, eop_o},         8'h00);
    chk({tag, "_eop_al"},  {7'd0, eop_aligned_o}, 8'h00);
    chk({tag, "_stuff"},   {7'd0, stuff_err_o},   8'h00);
  endtask

  initial begin
    m_acc = 8'h00; m_pending = 0; m_ones = 0;
    repeat (3) @(negedge clk12_i);
    check_outputs_zero("reset");
    rst_ni = 1'b1;

    // Sub-threshold "001" must not sync; seven zeros then one must.
    add_sym(1'b0, 1'b0, EV_NONE, 8'h00, 1'b0);
    add_sym(1'b0, 1'b0, EV_NONE, 8'h00, 1'b0);
    add_sym(1'b1, 1'b0, EV_NONE, 8'h00, 1'b0);
    add_sync(7);
    push_byte_bits(8'hA5);
    encode_dq();
    add_eop();
    run_syms(1'b0, -1);

    // Unstuffing with the SYNC one counted: 1111111 0000 -> 7F, 3 spare bits.
    add_sync(3);
    for (int k = 0; k < 7; k++) dq.push_back(1'b1);
    for (int k = 0; k < 4; k++) dq.push_back(1'b0);
    encode_dq();
    add_eop();
    run_syms(1'b0, -1);

    // Aligned EOP after two bytes, then misaligned after two bytes + 3 bits.
    add_sync(10);
    push_rand_bits(16);
    encode_dq();
    add_eop();
    run_syms(1'b0, -1);
    add_sync(4);
    push_rand_bits(19);
    encode_dq();
    add_eop();
    run_syms(1'b0, -1);

    // Seven ones after SYNC.
    add_sync(5);
    for (int k = 0; k < 5; k++) add_data_bit(1'b1);
`ifdef USB_RX_STUFF_ERR_CHECK_EN
    add_sym(1'b1, 1'b0, EV_ERR, 8'h00, 1'b0);
    add_sym(1'b1, 1'b0, EV_NONE, 8'h00, 1'b0);
    for (int k = 0; k < 20; k++) add_sym(1'($urandom), 1'b0, EV_NONE, 8'h00, 1'b0);
    add_sym(1'b0, 1'b1, EV_NONE, 8'h00, 1'b0);
`else
    add_sym(1'b1, 1'b0, EV_NONE, 8'h00, 1'b0);
    add_data_bit(1'b1);
    add_data_bit(1'b0);
    m_ones = 0;
    push_rand_bits(17);
    encode_dq();
    add_eop();
`endif
    run_syms(1'b0, -1);

    // Reset in the middle of the second byte.
    add_sync(3);
    push_byte_bits(8'hA5);
    push_byte_bits(8'h3C);
    encode_dq();
    run_syms(1'b0, 14);
    chk("byte_held", byte_o, 8'hA5);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL pending_before_reset: got %0d outstanding, expected 0", exp_q.size());
    end
    #2 rst_ni = 1'b0;
    #1 check_outputs_zero("midrst");
    @(negedge clk12_i);
    rst_ni = 1'b1;
    // Without a fresh SYNC nothing may be assembled.
    for (int k = 0; k < 12; k++) begin
      add_sym(1'b1, 1'b0, EV_NONE, 8'h00, 1'b0);
      add_sym(1'b0, 1'b0, EV_NONE, 8'h00, 1'b0);
    end
    run_syms(1'b0, -1);

    // Random packets, each sent gap-free and again with random strobe gaps.
    for (int p = 0; p < 12; p++) begin
      bit saved[$];
      int nz;
      push_rand_bits($urandom_range(8, 40));
      saved = dq;
      nz = $urandom_range(3, 9);
      add_sync(nz);
      encode_dq();
      add_eop();
      run_syms(1'b0, -1);
      dq = saved;
      add_sync(nz);
      encode_dq();
      add_eop();
      run_syms(1'b1, -1);
    end

    repeat (5) @(negedge clk12_i);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_events: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rx_unstuff_deserializer.md
# rx_unstuff_deserializer

Receive-path stage that consumes the NRZI-decoded bit stream and turns it into packet bytes. Hunts for the SYNC pattern, strips stuffed zeros, deserializes LSB-first into bytes and reports end-of-packet and bit-stuffing violations to the packet decoder downstream. Runs on the 12 MHz full-speed bit clock. Consumes one bit per `valid_i` strobe from the clock-recovery logic.

## Interface
- `SYNC_MIN_ZEROS`, 3: consecutive decoded zeros (1..7) required before the terminating one that completes SYNC.
- `clk12_i`  in  1  12 MHz bit clock.
- `rst_ni`  in  1  Reset; asynchronous assert, active-low.
- `data_i`  in  1  NRZI-decoded bit; sampled only when `valid_i`=1.
- `valid_i`  in  1  Bit strobe, at most one per cycle.
- `se0_i`  in  1  Line is SE0 for the current bit; qualified by `valid_i`.
- `sync_o`  out  1  One-cycle pulse: SYNC detected, packet starts.
- `byte_o`  out  8  Assembled byte, first received bit in bit 0; held until the next byte.
- `byte_valid_o`  out  1  One-cycle pulse: `byte_o` is new.
- `eop_o`  out  1  One-cycle pulse: packet ended by SE0.
- `eop_aligned_o`  out  1  Valid with `eop_o`: 1 if no partial byte was pending.
- `stuff_err_o`  out  1  One-cycle pulse: bit-stuffing violation; packet aborted.

## Operation
- States: IDLE, RECV, DRAIN.
- IDLE:
  - `zero_cnt` (3 bit) increments on each valid 0 and saturates at 7.
  - Valid 1 with `zero_cnt`>=`SYNC_MIN_ZEROS`: pulse `sync_o`, go to RECV, `ones_cnt`=1, `bit_cnt`=0.
  - Valid 1 with `zero_cnt` below threshold: clear `zero_cnt`.
  - Valid SE0: clear `zero_cnt`.
- RECV, on each valid bit, first match wins:
  1. `se0_i`=1: pulse `eop_o`, set `eop_aligned_o`=(`bit_cnt`==0), discard any partial byte, go to IDLE with `zero_cnt`=0.
  2. `ones_cnt`==6 and `data_i`=0: stuffed bit. Drop it and clear `ones_cnt`.
  3. `ones_cnt`==6 and `data_i`=1: behaviour set by the configuration macro.
  4. Otherwise: shift `data_i` into bit 7 of the shift register (right shift) and increment `bit_cnt` (3 bit, wraps). `ones_cnt` increments on 1, clears on 0.
- When `bit_cnt` wraps 7->0, load `byte_o` from the shift register and pulse `byte_valid_o`.
- DRAIN: ignore all data until a valid SE0, then go to IDLE. No `eop_o` is generated for an aborted packet.
- `data_i` and `se0_i` are ignored in every state whenever `valid_i`=0.

## Timing
- Reset values:
  - outputs: `byte_o`=8'h00, all pulse outputs 0, `eop_aligned_o`=0.
  - state: IDLE, all counters 0.
- All outputs are registered. Every pulse is asserted in the cycle after the `valid_i` cycle that caused it.
- Byte latency: `byte_valid_o` follows the strobe carrying the 8th unstuffed bit by 1 cycle.
- `byte_valid_o` and `eop_o` never coincide, because SE0 takes priority and carries no data bit.
- A reset asserted mid-packet forces IDLE immediately and clears every output. No pulse is emitted.
- Back-to-back `valid_i` on every cycle must be sustained with no bit loss.

## Configuration
- `USB_RX_STUFF_ERR_CHECK_EN` defined:
  - A 1 after six consecutive ones pulses `stuff_err_o` and moves RECV->DRAIN.
  - The partial byte is discarded.
- Macro undefined:
  - That bit is treated as stuffed and dropped, and `ones_cnt` clears.
  - `stuff_err_o` is tied to 0 and DRAIN is unreachable.

## Test plan
- SYNC with default parameter: decoded bits 0000000 1 -> `sync_o` pulses once. Bits 00 1 -> no `sync_o`, state remains IDLE.
- Byte assembly: after SYNC, send bits 1,0,1,0,0,1,0,1 -> `byte_valid_o` with `byte_o`=8'hA5, one cycle after the 8th strobe.
- Unstuffing: after SYNC (`ones_cnt`=1), send 11111 0(stuffed) 11 then 0000 -> one byte, `byte_o`=8'h7F. Confirms the SYNC one counts toward the six.
- EOP: after two full bytes, send SE0 -> `eop_o`=1, `eop_aligned_o`=1. Repeat with 3 extra bits first -> `eop_aligned_o`=0 and no extra `byte_valid_o`.
- Stuff error, macro defined: send seven ones after SYNC -> `stuff_err_o` pulses. Subsequent bytes are suppressed until SE0, and no `eop_o` is emitted. Macro undefined: no `stuff_err_o`, reception continues.
- Reset and gaps: `rst_ni` low mid-byte -> all outputs 0 in the same cycle, and a new SYNC is required afterwards. Random `valid_i` gaps -> bytes identical to the gap-free run.
